spi_master_cfg: RTL

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: per-transfer mode, bit order, chip select and SCLK divider,
// all latched when a start is accepted.
module spi_master_cfg #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_l,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LEAD  = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] TRAIL = 2'd3;

    localparam int EC_W = $clog2(2 * DATA_W) + 1;
    localparam logic [CS_W:0]   NUM_CS_V  = (CS_W + 1)'(NUM_CS);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    logic [1:0]        state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic [EC_W-1:0]   edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic [NUM_CS-1:0] cs_dec;
    logic              sel_ok;
    logic              leading;
    logic              last_edge;
    logic              shift_edge;
    logic              sample_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    assign sel_ok    = ({1'b0, cs_sel} < NUM_CS_V);
    assign busy      = (state != IDLE);
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == LAST_EDGE);
    // cpha=0 keeps the final bit on MOSI after the last trailing edge instead of shifting
    assign shift_edge  = cpha_q ? leading : (~leading & ~last_edge);
    assign sample_edge = cpha_q ? ~leading : leading;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_l <= '1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && sel_ok) begin
                        state    <= LEAD;
                        cnt      <= clk_div;
                        div_q    <= clk_div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_first;
                        edge_cnt <= '0;
                        rx_sh    <= '0;
                        spi_sclk <= cpol;
                        spi_cs_l <= cs_dec;
                        if (!cpha) begin
                            spi_mosi <= first_bit(tx_data, lsb_first);
                            tx_sh    <= shift_word(tx_data, lsb_first);
                        end else begin
                            tx_sh    <= tx_data;
                        end
                    end
                end
                LEAD: begin
                    if (cnt == '0) begin
                        cnt   <= div_q;
                        state <= XFER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                XFER: begin
                    if (cnt == '0) begin
                        cnt      <= div_q;
                        spi_sclk <= ~spi_sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (shift_edge) begin
                            spi_mosi <= first_bit(tx_sh, lsb_q);
                            tx_sh    <= shift_word(tx_sh, lsb_q);
                        end
                        if (sample_edge) begin
                            rx_sh <= lsb_q ? {spi_miso, rx_sh[DATA_W-1:1]}
                                           : {rx_sh[DATA_W-2:0], spi_miso};
                        end
                        if (last_edge) state <= TRAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TRAIL: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        spi_cs_l <= '1;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    spi_cs_l <= '1;
                    spi_sclk <= cpol_q;
                end
            endcase
        end
    end

endmodule
